// File: rtl/uart_tx_monitor.sv
// Host-side UART receiver for the CPU Tx line: 16x oversampled start/data/parity/stop
// framing into a first-word-fall-through byte FIFO with sticky error flags.
module uart_tx_monitor #(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int PARITY_MODE  = 0,
  parameter int FIFO_ADDR_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_empty,
  output logic       full,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH   = 2 ** FIFO_ADDR_W;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, S_BREAK} state_t;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             rx_meta, rx_sync;

  state_t           state, state_nxt;
  logic [3:0]       sc, sc_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             par_bit, par_bit_nxt;
  logic             par_good;
  logic             push, set_fe, set_pe;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_ADDR_W:0] wr_ptr, rd_ptr;
  logic               pop, wr_ok;

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_comb begin
    par_good = 1'b1;
    if (PARITY_MODE == 1) begin
      par_good = (^{shreg, par_bit}) == 1'b0;
    end else if (PARITY_MODE == 2) begin
      par_good = (^{shreg, par_bit}) == 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sc      <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_nxt;
      sc      <= sc_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      par_bit <= par_bit_nxt;
    end
  end

  // Data, parity and stop are sampled at sc=15, i.e. mid-bit once START has aligned sc to the bit centre.
  always_comb begin
    state_nxt   = state;
    sc_nxt      = sc;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    par_bit_nxt = par_bit;
    push        = 1'b0;
    set_fe      = 1'b0;
    set_pe      = 1'b0;
    case (state)
      IDLE: begin
        if (tick && !rx_sync) begin
          sc_nxt    = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (tick) begin
          if (sc == 4'd7) begin
            if (!rx_sync) begin
              sc_nxt      = '0;
              bit_idx_nxt = '0;
              state_nxt   = DATA;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            sc_nxt = sc + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sc_nxt = sc + 4'd1;
          if (sc == 4'd15) begin
            shreg_nxt[bit_idx] = rx_sync;
            bit_idx_nxt        = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
            end
          end
        end
      end
      PARITY: begin
        if (tick) begin
          sc_nxt = sc + 4'd1;
          if (sc == 4'd15) begin
            par_bit_nxt = rx_sync;
            state_nxt   = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          sc_nxt = sc + 4'd1;
          if (sc == 4'd15) begin
            if (rx_sync) begin
              push      = par_good;
              set_pe    = !par_good;
              state_nxt = IDLE;
            end else begin
              set_fe    = 1'b1;
              state_nxt = S_BREAK;
            end
          end
        end
      end
      S_BREAK: begin
        if (rx_sync) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_empty = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[FIFO_ADDR_W] != rd_ptr[FIFO_ADDR_W]) &&
                    (wr_ptr[FIFO_ADDR_W-1:0] == rd_ptr[FIFO_ADDR_W-1:0]);
  assign pop      = rd_en && !rd_empty;
  assign wr_ok    = push && (!full || pop);
  assign rd_data  = rd_empty ? 8'h00 : mem[rd_ptr[FIFO_ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[FIFO_ADDR_W-1:0]] <= shreg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + (FIFO_ADDR_W + 1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (FIFO_ADDR_W + 1)'(1);
      end
    end
  end

  // A new event in the same cycle as err_clr wins, so no error is ever lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= (frame_err  & ~err_clr) | set_fe;
      parity_err <= (parity_err & ~err_clr) | set_pe;
      overrun    <= (overrun    & ~err_clr) | (push & full & ~pop);
    end
  end

endmodule

// File: tb/tb_uart_tx_monitor.sv
// Bench for uart_tx_monitor: two instances (no parity / depth 16, odd parity / depth 4)
// checked every cycle against a frame-level event model with a queue-style FIFO.
module tb_uart_tx_monitor;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] rx = 2'b11;
  logic [1:0] rd_en = 2'b00;
  logic [1:0] err_clr = 2'b00;
  logic [7:0] rd_data0, rd_data1;
  logic [1:0] rd_empty, full, frame_err, parity_err, overrun;

  uart_tx_monitor #(.SYS_CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY_MODE(0), .FIFO_ADDR_W(4)) dut0 (
    .clk(clk), .rst(rst), .rx(rx[0]), .rd_en(rd_en[0]), .rd_data(rd_data0),
    .rd_empty(rd_empty[0]), .full(full[0]), .frame_err(frame_err[0]),
    .parity_err(parity_err[0]), .overrun(overrun[0]), .err_clr(err_clr[0])
  );

  uart_tx_monitor #(.SYS_CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY_MODE(2), .FIFO_ADDR_W(2)) dut1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .rd_en(rd_en[1]), .rd_data(rd_data1),
    .rd_empty(rd_empty[1]), .full(full[1]), .frame_err(frame_err[1]),
    .parity_err(parity_err[1]), .overrun(overrun[1]), .err_clr(err_clr[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    longint     at;
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mf [2][16];
  int         mcnt [2];
  logic [1:0] mfe = 2'b00, mpe = 2'b00, mov = 2'b00;
  logic [1:0] smp_rd = 2'b00, smp_clr = 2'b00;
  longint     cyc = 0;
  int         n_total = 0;
  int         n_bad = 0;
  bit         rand_on = 1'b0;

  function automatic int par_mode(int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic int depth(int i);
    return (i == 0) ? 16 : 4;
  endfunction

  task automatic check_output(string name, logic [15:0] act, logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Applies the frame outcomes scheduled for this edge plus the sampled pops and clears.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        mcnt[i] = 0;
        mfe[i]  = 1'b0;
        mpe[i]  = 1'b0;
        mov[i]  = 1'b0;
      end else begin
        bit         pop_m, push_m, pe, fe, ov;
        logic [7:0] d;
        pop_m  = smp_rd[i] && (mcnt[i] > 0);
        push_m = 1'b0;
        pe     = 1'b0;
        fe     = 1'b0;
        d      = 8'h00;
        for (int k = evq.size() - 1; k >= 0; k--) begin
          if (evq[k].idx == i && evq[k].at == cyc) begin
            if (evq[k].kind == 0) begin
              push_m = 1'b1;
              d      = evq[k].data;
            end else if (evq[k].kind == 1) begin
              pe = 1'b1;
            end else begin
              fe = 1'b1;
            end
            evq.delete(k);
          end
        end
        ov = push_m && (mcnt[i] == depth(i)) && !pop_m;
        if (pop_m) begin
          for (int j = 0; j < 15; j++) mf[i][j] = mf[i][j+1];
          mcnt[i]--;
        end
        if (push_m && !ov) begin
          mf[i][mcnt[i]] = d;
          mcnt[i]++;
        end
        mfe[i] = (mfe[i] & ~smp_clr[i]) | fe;
        mpe[i] = (mpe[i] & ~smp_clr[i]) | pe;
        mov[i] = (mov[i] & ~smp_clr[i]) | ov;
      end
    end
    if (!rst) evq.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      smp_rd  = rd_en;
      smp_clr = err_clr;
      @(negedge clk);
      model_step();
      for (int i = 0; i < 2; i++) begin
        logic [4:0] exp_st, act_st;
        logic [7:0] exp_rd, act_rd;
        exp_st = {mcnt[i] == 0, mcnt[i] == depth(i), mfe[i], mpe[i], mov[i]};
        act_st = {rd_empty[i], full[i], frame_err[i], parity_err[i], overrun[i]};
        exp_rd = (mcnt[i] == 0) ? 8'h00 : mf[i][0];
        act_rd = (i == 0) ? rd_data0 : rd_data1;
        check_output($sformatf("status%0d", i), 16'(act_st), 16'(exp_st));
        check_output($sformatf("rd_data%0d", i), 16'(act_rd), 16'(exp_rd));
      end
    end
  end

  initial begin
    #1000000;
    n_bad++;
    $display("[TB] FAIL watchdog: run did not finish, got timeout want completion");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick_wait(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame bit-by-bit and schedules its outcome at the stop-sample edge.
  task automatic send_frame(int i, logic [7:0] d, bit par_ok, bit stop_ok);
    ev_t  e;
    bit   has_par;
    logic p;
    has_par = (par_mode(i) != 0);
    p = (par_mode(i) == 1) ? ^d : ~^d;
    if (!par_ok) p = ~p;
    e.idx  = i;
    e.at   = cyc + 155 + (has_par ? 16 : 0);
    e.data = d;
    e.kind = !stop_ok ? 2 : (has_par && !par_ok) ? 1 : 0;
    evq.push_back(e);
    rx[i] = 1'b0;
    tick_wait(16);
    for (int b = 0; b < 8; b++) begin
      rx[i] = d[b];
      tick_wait(16);
    end
    if (has_par) begin
      rx[i] = p;
      tick_wait(16);
    end
    rx[i] = stop_ok;
    tick_wait(16);
    rx[i] = 1'b1;
  endtask

  task automatic glitch(int i, int len);
    rx[i] = 1'b0;
    tick_wait(len);
    rx[i] = 1'b1;
    tick_wait(12);
  endtask

  task automatic pop(int i);
    rd_en[i] = 1'b1;
    tick_wait(1);
    rd_en[i] = 1'b0;
  endtask

  task automatic clear(int i);
    err_clr[i] = 1'b1;
    tick_wait(1);
    err_clr[i] = 1'b0;
  endtask

  task automatic drive_random(int i, int n);
    for (int f = 0; f < n; f++) begin
      logic [7:0] d;
      bit         pok, sok;
      int         gap;
      d   = 8'($urandom);
      pok = (i == 0) || ($urandom_range(0, 4) != 0);
      sok = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) == 0) glitch(i, int'($urandom_range(1, 7)));
      send_frame(i, d, pok, sok);
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 0;
      if (!sok && gap < 2) gap = 2;
      tick_wait(gap);
    end
  endtask

  task automatic apply_stimulus();
    longint s;
    // Basic frame and its push latency from the start edge.
    s = cyc;
    fork
      send_frame(0, 8'h5A, 1'b1, 1'b1);
      begin
        longint t;
        t = -1;
        for (int k = 0; k < 300; k++) begin
          @(negedge clk);
          if (!rd_empty[0]) begin
            t = cyc - s;
            break;
          end
        end
        check_output("basic_latency", 16'(t), 16'd155);
      end
    join
    check_output("basic_data", 16'(rd_data0), 16'h005A);
    check_output("basic_flags", 16'({frame_err[0], parity_err[0], overrun[0]}), 16'd0);
    pop(0);
    check_output("basic_empty", 16'(rd_empty[0]), 16'd1);
    tick_wait(20);

    glitch(0, 4);
    check_output("glitch_state", 16'({rd_empty[0], frame_err[0], parity_err[0]}), 16'b100);
    send_frame(0, 8'h00, 1'b1, 1'b1);
    check_output("after_glitch", 16'({rd_empty[0], rd_data0}), 16'h0000);
    pop(0);
    tick_wait(20);

    send_frame(0, 8'hA5, 1'b1, 1'b0);
    rx[0] = 1'b0;
    tick_wait(400);
    rx[0] = 1'b1;
    tick_wait(20);
    send_frame(0, 8'h3C, 1'b1, 1'b1);
    check_output("break_ferr", 16'(frame_err[0]), 16'd1);
    check_output("break_data", 16'(rd_data0), 16'h003C);
    pop(0);
    check_output("break_only_one", 16'(rd_empty[0]), 16'd1);
    clear(0);
    check_output("break_clr", 16'(frame_err[0]), 16'd0);
    tick_wait(20);

    send_frame(1, 8'h07, 1'b1, 1'b1);
    check_output("odd_good", 16'({rd_empty[1], parity_err[1], rd_data1}), 16'h0007);
    send_frame(1, 8'h07, 1'b0, 1'b1);
    check_output("odd_bad_perr", 16'(parity_err[1]), 16'd1);
    pop(1);
    check_output("odd_bad_dropped", 16'(rd_empty[1]), 16'd1);
    clear(1);
    check_output("odd_clr", 16'(parity_err[1]), 16'd0);
    tick_wait(20);

    for (int d = 1; d <= 5; d++) send_frame(1, 8'(d), 1'b1, 1'b1);
    check_output("ovr_full", 16'({full[1], overrun[1]}), 16'b11);
    for (int d = 1; d <= 4; d++) begin
      check_output("ovr_pop", 16'(rd_data1), 16'(d));
      pop(1);
    end
    check_output("ovr_drained", 16'(rd_empty[1]), 16'd1);
    clear(1);
    for (int d = 1; d <= 4; d++) send_frame(1, 8'(d), 1'b1, 1'b1);
    s = cyc;
    fork
      send_frame(1, 8'h05, 1'b1, 1'b1);
      begin
        tick_wait(int'(s + 170 - cyc));
        rd_en[1] = 1'b1;
        tick_wait(1);
        rd_en[1] = 1'b0;
      end
    join
    check_output("popush_flags", 16'({full[1], overrun[1]}), 16'b10);
    for (int d = 2; d <= 5; d++) begin
      check_output("popush_pop", 16'(rd_data1), 16'(d));
      pop(1);
    end
    check_output("popush_drained", 16'(rd_empty[1]), 16'd1);
    tick_wait(20);

    send_frame(0, 8'h11, 1'b1, 1'b1);
    send_frame(0, 8'h22, 1'b1, 1'b1);
    fork
      send_frame(0, 8'hFF, 1'b1, 1'b1);
      begin
        tick_wait(16 * 4 + 8);
        rst = 1'b0;
        tick_wait(3);
        check_output("rst_outputs", 16'({rd_empty, full, frame_err, parity_err, overrun}), 16'h0300);
        rst = 1'b1;
      end
    join
    tick_wait(20);
    send_frame(0, 8'h81, 1'b1, 1'b1);
    check_output("post_rst_data", 16'({rd_empty[0], rd_data0}), 16'h0081);
    pop(0);
    tick_wait(20);

    rand_on = 1'b1;
    fork
      begin
        fork
          drive_random(0, 40);
          drive_random(1, 40);
        join
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          rd_en   = {$urandom_range(0, 299) == 0, $urandom_range(0, 99) == 0};
          err_clr = {$urandom_range(0, 499) == 0, $urandom_range(0, 499) == 0};
          tick_wait(1);
        end
        rd_en   = 2'b00;
        err_clr = 2'b00;
      end
    join
    tick_wait(20);
  endtask

  initial begin
    rst = 1'b0;
    tick_wait(3);
    check_output("reset_state", 16'({rd_empty, full, frame_err, parity_err, overrun}), 16'h0300);
    check_output("reset_rd_data", 16'({rd_data0, rd_data1}), 16'h0000);
    rst = 1'b1;
    tick_wait(5);
    apply_stimulus();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
